// File: rtl/dma_dsc_byp_arbiter.sv
// Round-robin descriptor-bypass arbiter that splits descriptors at MAX_CHUNK boundaries.
// Optional DSC_BYP_STATS_EN adds per-channel descriptor and total chunk counters.
module dma_dsc_byp_arbiter #(
  parameter int N_CHAN    = 4,
  parameter int MAX_CHUNK = 4096,
  parameter int ADDR_W    = 64,
  parameter int LEN_W     = 32,
  localparam int CW = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic                     pcie_clk,
  input  logic                     pcie_aresetn,
  input  logic [N_CHAN-1:0]        s_dsc_load,
  output logic [N_CHAN-1:0]        s_dsc_ready,
  input  logic [N_CHAN*ADDR_W-1:0] s_dsc_addr,
  input  logic [N_CHAN*LEN_W-1:0]  s_dsc_len,
  input  logic                     m_dsc_ready,
  output logic                     m_dsc_load,
  output logic [ADDR_W-1:0]        m_dsc_addr,
  output logic [LEN_W-1:0]         m_dsc_len,
  output logic [CW-1:0]            m_dsc_chan,
  output logic                     m_dsc_last,
  output logic [N_CHAN-1:0]        zero_len_err,
  output logic                     busy
`ifdef DSC_BYP_STATS_EN
  ,
  output logic [N_CHAN*32-1:0]     stat_dsc_cnt,
  output logic [31:0]              stat_chunk_cnt
`endif
);

  localparam int O   = $clog2(MAX_CHUNK);
  localparam int CLW = LEN_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    ISSUE
  } state_e;

  state_e state_q, state_d;

  logic [N_CHAN-1:0] full_q, full_d;
  logic [N_CHAN-1:0] zerr_q, zerr_d;
  logic [N_CHAN-1:0][ADDR_W-1:0] haddr_q, haddr_d;
  logic [N_CHAN-1:0][LEN_W-1:0] hlen_q, hlen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [CW-1:0] chan_q, chan_d;
  logic [CW-1:0] rr_q, rr_d;
  logic [CW-1:0] grant;
  logic [CLW-1:0] bnd, chunk;
  logic [N_CHAN-1:0] chan_oh;
  logic issue, fire, last, found;

  always_comb begin
    grant = rr_q;
    found = 1'b0;
    for (int k = 0; k < N_CHAN; k++) begin
      if (!found && full_q[(int'(rr_q) + k) % N_CHAN]) begin
        found = 1'b1;
        grant = CW'((int'(rr_q) + k) % N_CHAN);
      end
    end
  end

  // Bytes left before the next MAX_CHUNK-aligned address.
  assign bnd   = CLW'(MAX_CHUNK) - CLW'(addr_q[O-1:0]);
  assign chunk = ({1'b0, rem_q} < bnd) ? {1'b0, rem_q} : bnd;
  assign last  = ({1'b0, rem_q} == chunk);
  assign issue = (state_q == ISSUE);
  assign fire  = issue & m_dsc_ready;

  assign chan_oh      = N_CHAN'(1) << chan_q;
  assign m_dsc_load   = fire;
  assign m_dsc_addr   = issue ? addr_q : '0;
  assign m_dsc_len    = issue ? chunk[LEN_W-1:0] : '0;
  assign m_dsc_chan   = issue ? chan_q : '0;
  assign m_dsc_last   = issue & last;
  assign s_dsc_ready  = ~full_q;
  assign zero_len_err = zerr_q;
  assign busy         = (|full_q) | (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    full_d  = full_q;
    zerr_d  = '0;
    haddr_d = haddr_q;
    hlen_d  = hlen_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    chan_d  = chan_q;
    rr_d    = rr_q;
    for (int i = 0; i < N_CHAN; i++) begin
      if (s_dsc_load[i] && !full_q[i]) begin
        if (s_dsc_len[i*LEN_W +: LEN_W] == '0) begin
          zerr_d[i] = 1'b1;
        end else begin
          full_d[i]  = 1'b1;
          haddr_d[i] = s_dsc_addr[i*ADDR_W +: ADDR_W];
          hlen_d[i]  = s_dsc_len[i*LEN_W +: LEN_W];
        end
      end
    end
    unique case (state_q)
      IDLE: begin
        if (|full_q) state_d = ARB;
      end
      ARB: begin
        chan_d  = grant;
        addr_d  = haddr_q[grant];
        rem_d   = hlen_q[grant];
        rr_d    = (int'(grant) == N_CHAN - 1) ? '0 : grant + 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (m_dsc_ready) begin
          addr_d = addr_q + ADDR_W'(chunk);
          rem_d  = rem_q - chunk[LEN_W-1:0];
          if (last) begin
            full_d[chan_q] = 1'b0;
            state_d = (|(full_q & ~chan_oh)) ? ARB : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
    if (!pcie_aresetn) begin
      state_q <= IDLE;
      full_q  <= '0;
      zerr_q  <= '0;
      haddr_q <= '0;
      hlen_q  <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      chan_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      zerr_q  <= zerr_d;
      haddr_q <= haddr_d;
      hlen_q  <= hlen_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      chan_q  <= chan_d;
      rr_q    <= rr_d;
    end
  end

`ifdef DSC_BYP_STATS_EN
  logic [N_CHAN-1:0][31:0] sdsc_q, sdsc_d;
  logic [31:0] schunk_q, schunk_d;

  always_comb begin
    sdsc_d   = sdsc_q;
    schunk_d = schunk_q + (fire ? 32'd1 : 32'd0);
    for (int i = 0; i < N_CHAN; i++) begin
      if (s_dsc_load[i] && !full_q[i] &&
          (s_dsc_len[i*LEN_W +: LEN_W] != '0)) begin
        sdsc_d[i] = sdsc_q[i] + 32'd1;
      end
    end
  end

  always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
    if (!pcie_aresetn) begin
      sdsc_q   <= '0;
      schunk_q <= '0;
    end else begin
      sdsc_q   <= sdsc_d;
      schunk_q <= schunk_d;
    end
  end

  assign stat_dsc_cnt   = sdsc_q;
  assign stat_chunk_cnt = schunk_q;
`endif

endmodule

// File: tb/tb_dma_dsc_byp_arbiter.sv
// Bench for dma_dsc_byp_arbiter: directed scenarios plus random traffic
// scored against per-channel chunk lists derived from boundary arithmetic.
module tb_dma_dsc_byp_arbiter;

  localparam int N   = 4;
  localparam int MAX = 4096;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] len;
    logic [1:0]  chan;
    logic        last;
    int          cyc;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  s_dsc_load = '0;
  logic [N-1:0]  s_dsc_ready;
  logic [N*64-1:0] s_dsc_addr = '0;
  logic [N*32-1:0] s_dsc_len = '0;
  logic          m_dsc_ready = 1'b1;
  logic          m_dsc_load;
  logic [63:0]   m_dsc_addr;
  logic [31:0]   m_dsc_len;
  logic [1:0]    m_dsc_chan;
  logic          m_dsc_last;
  logic [N-1:0]  zero_len_err;
  logic          busy;
`ifdef DSC_BYP_STATS_EN
  logic [N*32-1:0] stat_dsc_cnt;
  logic [31:0]     stat_chunk_cnt;
`endif

  dma_dsc_byp_arbiter #(
    .N_CHAN(N), .MAX_CHUNK(MAX), .ADDR_W(64), .LEN_W(32)
  ) dut (
    .pcie_clk(clk),
    .pcie_aresetn(rst_n),
    .s_dsc_load(s_dsc_load),
    .s_dsc_ready(s_dsc_ready),
    .s_dsc_addr(s_dsc_addr),
    .s_dsc_len(s_dsc_len),
    .m_dsc_ready(m_dsc_ready),
    .m_dsc_load(m_dsc_load),
    .m_dsc_addr(m_dsc_addr),
    .m_dsc_len(m_dsc_len),
    .m_dsc_chan(m_dsc_chan),
    .m_dsc_last(m_dsc_last),
    .zero_len_err(zero_len_err),
    .busy(busy)
`ifdef DSC_BYP_STATS_EN
    ,
    .stat_dsc_cnt(stat_dsc_cnt),
    .stat_chunk_cnt(stat_chunk_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rec_t log_q[$];
  always @(negedge clk)
    if (rst_n && m_dsc_load)
      log_q.push_back('{m_dsc_addr, m_dsc_len, m_dsc_chan, m_dsc_last, cyc});

  int   tests = 0;
  int   fails = 0;
  rec_t expq[N][$];
  int   rd = 0;
  logic in_desc = 1'b0;
  logic [1:0] cur_ch = '0;
  int   acc_cyc;

  logic [63:0] t2a [4] = '{64'h0F00, 64'h1000, 64'h2000, 64'h3000};
  logic [31:0] t2l [4] = '{32'd256, 32'd4096, 32'd4096, 32'd1552};
  logic [1:0]  t3c [5] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0};

  function automatic void check(string tag, logic [127:0] obs,
                                logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  // Expected chunks: cut at each MAX-aligned boundary until length is used up.
  function automatic void model(int ch, logic [63:0] a, logic [31:0] l);
    longint unsigned rem = l;
    longint unsigned c;
    logic [63:0] ad = a;
    while (rem > 0) begin
      c = MAX - (ad % MAX);
      if (c > rem) c = rem;
      expq[ch].push_back('{ad, c[31:0], 2'(ch), c == rem, 0});
      ad  = ad + c;
      rem = rem - c;
    end
  endfunction

  task automatic score();
    rec_t r;
    rec_t e;
    while (rd < log_q.size()) begin
      r = log_q[rd];
      rd++;
      if (in_desc) check("no_preempt", r.chan, cur_ch);
      in_desc = !r.last;
      cur_ch  = r.chan;
      check("sb_has_exp", expq[r.chan].size() == 0, 0);
      if (expq[r.chan].size() != 0) begin
        e = expq[r.chan].pop_front();
        check("sb_chunk", {r.addr, r.len, r.last}, {e.addr, e.len, e.last});
      end
    end
  endtask

  task automatic do_reset();
    score();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) expq[i].delete();
    in_desc = 1'b0;
    s_dsc_load  = '0;
    m_dsc_ready = 1'b1;
    @(negedge clk);
    check("rst_ready", s_dsc_ready, 4'hF);
    check("rst_load", m_dsc_load, 0);
    check("rst_addr_len", {m_dsc_addr, m_dsc_len}, 0);
    check("rst_chan_last", {m_dsc_chan, m_dsc_last}, 0);
    check("rst_zerr", zero_len_err, 0);
    check("rst_busy", busy, 0);
`ifdef DSC_BYP_STATS_EN
    check("rst_stats", {stat_dsc_cnt, stat_chunk_cnt}, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send(int ch, logic [63:0] ad, logic [31:0] ln);
    int n = 0;
    s_dsc_addr[ch*64 +: 64] = ad;
    s_dsc_len[ch*32 +: 32]  = ln;
    s_dsc_load[ch] = 1'b1;
    while (!s_dsc_ready[ch] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 200) check("send_timeout", s_dsc_ready[ch], 1);
    acc_cyc = cyc;
    if (ln != 0) model(ch, ad, ln);
    @(posedge clk); #1;
    s_dsc_load[ch] = 1'b0;
  endtask

  task automatic wait_log(int target, int lim);
    for (int n = 0; n < lim; n++) begin
      @(posedge clk); #1;
      if (log_q.size() >= target) break;
    end
    if (log_q.size() < target) check("log_timeout", log_q.size(), target);
  endtask

  task automatic wait_idle(int lim);
    for (int n = 0; n < lim; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int b;
    int a;
    longint sum;
    logic [N-1:0] ezerr;
    logic [63:0] ad;
    logic [31:0] ln;

    do_reset();

    // Single short descriptor: latency, ready handshake
    b = log_q.size();
    send(0, 64'h1000, 32'd100);
    a = acc_cyc;
    @(negedge clk);
    check("t1_ready_low", s_dsc_ready[0], 0);
    wait_log(b + 1, 10);
    if (log_q.size() > b) begin
      check("t1_latency", log_q[b].cyc - a, 3);
      check("t1_chunk", {log_q[b].addr, log_q[b].len, log_q[b].last,
                         log_q[b].chan}, {64'h1000, 32'd100, 1'b1, 2'd0});
    end
    @(negedge clk);
    check("t1_ready_back", s_dsc_ready[0], 1);
    check("t1_busy_off", busy, 0);
    score();

    // Split across 4 KiB boundaries, back-to-back
    b = log_q.size();
    send(1, 64'h0F00, 32'd10000);
    wait_idle(100);
    check("t2_count", log_q.size() - b, 4);
    if (log_q.size() >= b + 4)
      for (int k = 0; k < 4; k++) begin
        check("t2_chunk", {log_q[b+k].addr, log_q[b+k].len,
                           log_q[b+k].last, log_q[b+k].chan},
              {t2a[k], t2l[k], k == 3, 2'd1});
        check("t2_b2b", log_q[b+k].cyc - log_q[b].cyc, k);
      end
    score();

    // Round robin: ch0 and ch2 together, then ch0 again
    do_reset();
    b = log_q.size();
    s_dsc_addr[0 +: 64]   = 64'h10000;
    s_dsc_len[0 +: 32]    = 32'd8192;
    s_dsc_addr[128 +: 64] = 64'h20000;
    s_dsc_len[64 +: 32]   = 32'd8192;
    s_dsc_load = 4'b0101;
    model(0, 64'h10000, 32'd8192);
    model(2, 64'h20000, 32'd8192);
    @(posedge clk); #1;
    s_dsc_load = '0;
    send(0, 64'h30000, 32'd64);
    wait_idle(100);
    check("t3_count", log_q.size() - b, 5);
    if (log_q.size() >= b + 5)
      for (int k = 0; k < 5; k++)
        check("t3_order", log_q[b+k].chan, t3c[k]);
    score();

    // Stall in the middle of a split
    do_reset();
    b = log_q.size();
    send(1, 64'h0F00, 32'd10000);
    wait_log(b + 1, 20);
    m_dsc_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_stall_load", m_dsc_load, 0);
      check("t4_frozen", {m_dsc_addr, m_dsc_len, m_dsc_chan, m_dsc_last},
            {64'h1000, 32'd4096, 2'd1, 1'b0});
    end
    @(posedge clk); #1;
    m_dsc_ready = 1'b1;
    wait_idle(100);
    check("t4_count", log_q.size() - b, 4);
    sum = 0;
    for (int k = b; k < log_q.size(); k++) sum += log_q[k].len;
    check("t4_total", sum, 10000);
    score();

    // Zero length descriptor
    b = log_q.size();
    send(3, 64'h5000, 32'd0);
    @(negedge clk);
    check("t5_zerr_pulse", zero_len_err, 4'b1000);
    check("t5_ready", s_dsc_ready[3], 1);
    @(negedge clk);
    check("t5_zerr_clear", zero_len_err, 0);
    repeat (4) @(negedge clk);
    check("t5_no_load", log_q.size(), b);
    check("t5_busy", busy, 0);
    @(posedge clk); #1;

    // Reset during second chunk, then recover
    b = log_q.size();
    send(1, 64'h0F00, 32'd10000);
    wait_log(b + 1, 20);
    do_reset();
    b = log_q.size();
    send(0, 64'h0, 32'd64);
    wait_idle(50);
    check("t6_count", log_q.size() - b, 1);
    if (log_q.size() > b)
      check("t6_chunk", {log_q[b].addr, log_q[b].len, log_q[b].last,
                         log_q[b].chan}, {64'h0, 32'd64, 1'b1, 2'd0});
`ifdef DSC_BYP_STATS_EN
    check("t6_dsc_cnt", stat_dsc_cnt[31:0], 1);
    check("t6_chunk_cnt", stat_chunk_cnt, 1);
`endif
    score();

    // Random traffic with random back-pressure
    do_reset();
    ezerr = '0;
    for (int c = 0; c < 400; c++) begin
      check("rnd_zerr", zero_len_err, ezerr);
      ezerr = '0;
      m_dsc_ready = ($urandom_range(0, 3) != 0);
      for (int ch = 0; ch < N; ch++) begin
        s_dsc_load[ch] = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
          ad = {$urandom, $urandom};
          if ($urandom_range(0, 7) == 0) ad[63:16] = '1;
          case ($urandom_range(0, 15))
            0:       ln = 32'd0;
            1, 2, 3: ln = 32'($urandom_range(1, 200));
            default: ln = 32'($urandom_range(1, 20000));
          endcase
          s_dsc_addr[ch*64 +: 64] = ad;
          s_dsc_len[ch*32 +: 32]  = ln;
          s_dsc_load[ch] = 1'b1;
          if (s_dsc_ready[ch]) begin
            if (ln == 0) ezerr[ch] = 1'b1;
            else model(ch, ad, ln);
          end
        end
      end
      @(posedge clk); #1;
    end
    check("rnd_zerr", zero_len_err, ezerr);
    s_dsc_load  = '0;
    m_dsc_ready = 1'b1;
    wait_idle(5000);
    score();
    for (int ch = 0; ch < N; ch++)
      check("rnd_drained", expq[ch].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
